// File: rtl/string_detectore_pkg.sv
// Shared definitions for the mode-1 string generator/detector pair:
// state encoding, default widths and a frame-length helper.
package string_detectore_pkg;

    localparam int DEF_W  = 4;
    localparam int DEF_CW = 4;
    localparam int DEF_GW = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } gen_state_t;

    // Number of frame bits for `count` insertions separated by `gap` filler bits.
    function automatic int frame_len(input int count, input int gap, input int w);
        if (count == 0) return 0;
        return count * w + (count - 1) * gap;
    endfunction

endpackage

// File: rtl/string_generator_mode1_piso.sv
// W-bit parallel-in serial-out shift register; dout is always the current MSB.
module string_piso
    import string_detectore_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sr;

    // load wins over shift so a pattern reload on the last bit restarts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign dout = sr[W-1];

endmodule

// File: rtl/string_generator_mode1.sv
// Serial pattern transmitter: sends string1 `count` times MSB first with
// `gap` filler bits between insertions; all outputs are registered.
module string_generator_mode1
    import string_detectore_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW,
    parameter int GW = DEF_GW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  string1,
    input  logic [CW-1:0] count,
    input  logic [GW-1:0] gap,
    input  logic          fill,
    output logic          string2,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    gen_state_t    state, state_nxt;
    logic [W-1:0]  pat_l;
    logic [GW-1:0] gap_l;
    logic [GW-1:0] gap_left;
    logic          fill_l;
    logic [CW-1:0] rem;
    logic [BW-1:0] bit_idx;
    logic          load, shift, last_bit, dout, string2_nxt;

    assign last_bit = (bit_idx == '0);

    string_piso #(.W(W)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   ((state == IDLE) ? string1 : pat_l),
        .dout  (dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        shift       = 1'b0;
        string2_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SEND;
                        load      = 1'b1;
                    end
                end
            end
            SEND: begin
                string2_nxt = dout;
                if (!last_bit) begin
                    shift = 1'b1;
                end else if (rem == CW'(1)) begin
                    state_nxt = DONE;
                end else if (gap_l == '0) begin
                    load = 1'b1;
                end else begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                string2_nxt = fill_l;
                if (gap_left == GW'(1)) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame parameters are captured only at acceptance so later input changes are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_l    <= '0;
            gap_l    <= '0;
            fill_l   <= 1'b0;
            rem      <= '0;
            gap_left <= '0;
            bit_idx  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pat_l   <= string1;
                        gap_l   <= gap;
                        fill_l  <= fill;
                        rem     <= count;
                        bit_idx <= BW'(W - 1);
                    end
                end
                SEND: begin
                    if (last_bit) begin
                        rem      <= rem - 1'b1;
                        bit_idx  <= BW'(W - 1);
                        gap_left <= gap_l;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                GAP:  gap_left <= gap_left - 1'b1;
                default: ;
            endcase
        end
    end

    // Output stage delays the state-derived values by one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            string2 <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            string2 <= string2_nxt;
            valid   <= (state == SEND) || (state == GAP);
            busy    <= (state == SEND) || (state == GAP);
            done    <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_string_generator_mode1.sv
// Directed self-checking bench for string_generator_mode1; each scenario task
// compares {string2,valid,busy,done} every cycle against hand-derived values.
module tb_string_generator_mode1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] string1;
    logic [3:0] count;
    logic [3:0] gap;
    logic       fill;
    logic       string2, valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    string_generator_mode1 #(.W(4), .CW(4), .GW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .string1 (string1),
        .count   (count),
        .gap     (gap),
        .fill    (fill),
        .string2 (string2),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] s, input logic [3:0] c,
                          input logic [3:0] g, input logic f);
        string1 = s;
        count   = c;
        gap     = g;
        fill    = f;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0; string1 = '0; count = '0; gap = '0; fill = 1'b0;
        tick(); tick();
        if ({string2, valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL reset: s2/v/b/d got %b want 0000", {string2, valid, busy, done});
        end
        n_cmp++;
        rst_n = 1'b1;
        tick();
        if ({string2, valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL reset_idle: s2/v/b/d got %b want 0000", {string2, valid, busy, done});
        end
        n_cmp++;
    endtask

    task automatic test_single;
        logic [3:0] eb = 4'b0110;
        int t = 4;
        logic [3:0] exp_o;
        accept(4'b0110, 4'd1, 4'd0, 1'b0);
        for (int i = 1; i <= t + 2; i++) begin
            tick();
            exp_o = {(i <= t) ? eb[t-i] : 1'b0, i <= t, i <= t, i == t + 1};
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL single cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
        end
    endtask

    task automatic test_gap;
        logic [15:0] eb = 16'b0110_00_0110_00_0110;
        int t = 16;
        logic [3:0] exp_o;
        accept(4'b0110, 4'd3, 4'd2, 1'b0);
        for (int i = 1; i <= t + 2; i++) begin
            tick();
            exp_o = {(i <= t) ? eb[t-i] : 1'b0, i <= t, i <= t, i == t + 1};
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL gap cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] eb = 8'b1011_1011;
        int t = 8;
        logic [3:0] exp_o;
        accept(4'b1011, 4'd2, 4'd0, 1'b1);
        for (int i = 1; i <= t + 2; i++) begin
            tick();
            exp_o = {(i <= t) ? eb[t-i] : 1'b0, i <= t, i <= t, i == t + 1};
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL b2b cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
        end
    endtask

    task automatic test_count_zero;
        logic [3:0] exp_o;
        accept(4'b1111, 4'd0, 4'd3, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_o = {3'b000, i == 1};
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL count0 cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
        end
    endtask

    task automatic test_ignore_start;
        logic [8:0] eb = 9'b0110_1_0110;
        logic [3:0] eb2 = 4'b1111;
        int t = 9;
        logic [3:0] exp_o;
        accept(4'b0110, 4'd2, 4'd1, 1'b1);
        for (int i = 1; i <= t + 3; i++) begin
            tick();
            exp_o = {(i <= t) ? eb[t-i] : 1'b0, i <= t, i <= t, i == t + 1};
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL ignore cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
            // mid-frame request with new inputs, and a request sampled during DONE
            if (i == 3) begin string1 = 4'b1111; count = 4'd5; gap = 4'd0; fill = 1'b0; start = 1'b1; end
            if (i == 4) start = 1'b0;
            if (i == t) start = 1'b1;
            if (i == t + 1) start = 1'b0;
        end
        accept(4'b1111, 4'd1, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_o = {(i <= 4) ? eb2[4-i] : 1'b0, i <= 4, i <= 4, i == 5};
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL restart cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_midframe_and_max;
        logic [3:0] pat = 4'b1011;
        int t = 270;
        int p;
        int nvalid = 0;
        int ndone = 0;
        logic es;
        logic [3:0] exp_o;
        accept(4'b0110, 4'd3, 4'd2, 1'b1);
        for (int i = 1; i <= 5; i++) tick();
        if ({string2, valid, busy, done} !== 4'b1110) begin
            n_err++;
            $display("[TB] FAIL pre_abort: s2/v/b/d got %b want 1110", {string2, valid, busy, done});
        end
        n_cmp++;
        #2 rst_n = 1'b0;
        #1;
        if ({string2, valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL async_abort: s2/v/b/d got %b want 0000", {string2, valid, busy, done});
        end
        n_cmp++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        if ({string2, valid, busy, done} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL post_abort: s2/v/b/d got %b want 0000", {string2, valid, busy, done});
        end
        n_cmp++;
        accept(pat, 4'd15, 4'd15, 1'b1);
        for (int i = 1; i <= t + 2; i++) begin
            tick();
            p  = (i - 1) % 19;
            es = (i > t) ? 1'b0 : (p < 4) ? pat[3-p] : 1'b1;
            exp_o = {es, i <= t, i <= t, i == t + 1};
            if (valid === 1'b1) nvalid++;
            if (done === 1'b1) ndone++;
            if ({string2, valid, busy, done} !== exp_o) begin
                n_err++;
                $display("[TB] FAIL max cyc%0d: s2/v/b/d got %b want %b", i, {string2, valid, busy, done}, exp_o);
            end
            n_cmp++;
        end
        if (nvalid != t || ndone != 1) begin
            n_err++;
            $display("[TB] FAIL max_totals: valid %0d done %0d, want valid %0d done 1", nvalid, ndone, t);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_count_zero();
        test_ignore_start();
        test_reset_midframe_and_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/string_generator_mode1.md
Name: string_generator_mode1

Overview:
- Serial pattern transmitter; the driving end of the string2 bit-stream that the mode-1 string detector consumes.
- Frame content: a 4-bit pattern (string1) inserted `count` times, MSB first, with `gap` filler bits between insertions.
- Used as the stimulus source for detector benches and for on-chip loopback checks. Output is registered on the rising edge of clk.

Parameters:
W, 4, pattern width in bits (string1 width)
CW, 4, width of insertion-count input
GW, 4, width of gap-length input

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
start  in  1  request a frame; sampled only in IDLE
string1  in  W  pattern to transmit; latched on start acceptance
count  in  CW  number of pattern insertions; latched on acceptance
gap  in  GW  filler bits between consecutive insertions; latched on acceptance
fill  in  1  filler bit value; latched on acceptance
string2  out  1  serial bit stream; detector input
valid  out  1  high when string2 carries a frame bit
busy  out  1  high from the cycle after acceptance through the last frame bit
done  out  1  one-cycle pulse after the last bit (or after acceptance when count==0)

Behaviour:
- Reset, asynchronous while rst_n=0: state=IDLE; string2=0, valid=0, busy=0, done=0; all counters and latches cleared.
- A reset assertion mid-frame aborts the frame immediately. No done pulse is produced.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - When start=1 at a rising edge, latch string1/count/gap/fill.
  - If count==0, go to DONE.
  - Otherwise go to SEND: load shift register with the pattern, bit index = W-1, insertions remaining = count.
  - string2=0 and valid=0 in IDLE.
- SEND:
  - One bit per cycle, MSB first: string2 = pat[W-1], then pat[W-2], ... pat[0]. valid=1 and busy=1.
  - After bit 0, decrement insertions remaining.
  - If remaining==0, go to DONE (no trailing gap).
  - Else if gap==0, reload the pattern and stay in SEND, back-to-back with no idle cycle.
  - Else go to GAP.
- GAP: string2=fill, valid=1, busy=1 for exactly `gap` cycles, then reload the pattern and go to SEND.
- DONE: done=1, valid=0, busy=0, string2=0 for one cycle, then IDLE.
- start is ignored outside IDLE, including in DONE. The earliest next acceptance is the edge after the done cycle.
- Input changes after acceptance have no effect on the frame in progress.
- Timing, with acceptance at edge k:
  - Frame bits are present after edges k+1 .. k+T, where T = count*W + (count-1)*gap.
  - done is high after edge k+T+1.
  - For count==0, done is high after edge k+1.
- Counters are sized for max values without overflow: CW bits for insertions, GW bits for gap, clog2(W) bits for bit index.
  - Worst case W=4, count=15, gap=15 gives T=270 bits.
- Bench drivers sample string2 while valid=1, on the edge after it changes.

Decomposition:
- Shared package string_detectore_pkg holds:
  - state encoding localparams (IDLE, SEND, GAP, DONE);
  - default W/CW/GW;
  - a frame-length function T(count, gap, W) for benches.
- One sub-module, string_piso: W-bit parallel-in serial-out shift register.
  - Ports: load, shift, din[W-1:0], dout (MSB).
  - The FSM and counters stay in the top module.

Test Plan:
1. string1=0110, count=1, gap=0, start pulse -> string2 = 0,1,1,0 with valid=1 for 4 cycles; busy high those 4 cycles; done high on cycle 5.
2. string1=0110, count=3, gap=2, fill=0 -> 16 valid bits 0110 00 0110 00 0110; done on cycle 17; feeding string2 to string_detectore_mode1 (same pattern) yields N=3.
3. string1=1011, count=2, gap=0 -> 10111011 contiguous, no valid gap; done on cycle 9.
4. count=0 -> valid never asserts, busy stays 0, done high exactly 1 cycle after acceptance.
5. Start with string1=0110, count=2, gap=1, fill=1; mid-frame change string1 to 1111 and pulse start again -> output still 0110 1 0110; no second frame starts; the next start after done is accepted.
6. rst_n driven low between clock edges during GAP -> string2/valid/busy/done go 0 immediately with no clock; after release, count=15, gap=15 runs exactly 270 valid bits, then one done pulse.
